// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: two-client (I-cache / D-cache) arbiter in front of one
// single-port physical memory. One 128-bit block moves per grant.
//
// Optional feature: define LC3B_ARB_RR_EN to replace fixed D-cache priority
// with a 1-bit last-winner pointer, so simultaneous requesters alternate.
//
// Handshake: client requests (i_read, d_read, d_write) are levels held until
// the matching one-cycle *_resp pulse; the pmem strobes are held until the
// one-cycle pmem_resp pulse; pmem_resp is only honoured while a strobe is up.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 I_BUSY, 2 D_BUSY, 3 DONE.
module lc3b_mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_read,
  input  logic [ADDR_WIDTH-1:0]  i_address,
  output logic [BLOCK_WIDTH-1:0] i_rdata,
  output logic                   i_resp,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [ADDR_WIDTH-1:0]  d_address,
  input  logic [BLOCK_WIDTH-1:0] d_wdata,
  output logic [BLOCK_WIDTH-1:0] d_rdata,
  output logic                   d_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [BLOCK_WIDTH-1:0] pmem_wdata,
  input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
  input  logic                   pmem_resp,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_BUSY = 2'd1,
    S_D_BUSY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
  logic                   write_q, write_d;    // latched op: 1 = write
  logic                   owner_d_q, owner_d_d; // 1 = D-cache owns the transaction

  logic d_req;
  logic d_wins;

  assign d_req = d_read | d_write;

`ifdef LC3B_ARB_RR_EN
  // Last-winner pointer: 1 means the I-cache won the previous grant.
  // Resets to 1 so the D-cache wins the first simultaneous request.
  logic last_i_q, last_i_d;

  assign d_wins = d_req & (~i_read | last_i_q);

  // Pointer register, updated on every grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_i_q <= 1'b1;
    else          last_i_q <= last_i_d;
  end
`else
  // Fixed priority: any D-cache request beats the I-cache.
  assign d_wins = d_req;
`endif

  // State and latched-transaction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      owner_d_q <= owner_d_d;
    end
  end

  // Next-state: grant in IDLE, wait for memory in BUSY, one DONE bubble
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    owner_d_d = owner_d_q;
`ifdef LC3B_ARB_RR_EN
    last_i_d  = last_i_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (d_wins) begin
          state_d   = S_D_BUSY;
          addr_d    = {d_address[ADDR_WIDTH-1:4], 4'h0};
          wdata_d   = d_wdata;
          write_d   = d_write;  // read+write together counts as a write
          owner_d_d = 1'b1;
`ifdef LC3B_ARB_RR_EN
          last_i_d  = 1'b0;
`endif
        end else if (i_read) begin
          state_d   = S_I_BUSY;
          addr_d    = {i_address[ADDR_WIDTH-1:4], 4'h0};
          wdata_d   = d_wdata;
          write_d   = 1'b0;
          owner_d_d = 1'b0;
`ifdef LC3B_ARB_RR_EN
          last_i_d  = 1'b1;
`endif
        end
      end
      S_I_BUSY, S_D_BUSY: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Unconditional bubble so a request still high on the resp edge
        // is never granted a second time.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only, no request-to-pmem path
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    dbg_state    = state_q;
    case (state_q)
      S_I_BUSY: pmem_read = 1'b1;
      S_D_BUSY: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
      end
      S_DONE: begin
        if (owner_d_q) begin
          d_resp  = 1'b1;
          d_rdata = rdata_q;
        end else begin
          i_resp  = 1'b1;
          i_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule
